// File: rtl/data_mem_hs.sv
// Byte-addressable little-endian data memory with valid/ready request/response
// handshake, parametrised response latency and misalign/range error reporting.
module data_mem_hs #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_BYTES);
  localparam logic [2:0]  LAT_M1 = 3'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic          accept;
  logic          err;
  logic [32:0]   nbytes;
  logic [32:0]   end_addr;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   word;
  logic [31:0]   load_data;

  assign accept = req_valid && req_ready_q;

  // Range check is done on 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    nbytes = 33'd4;
    unique case (req_size)
      2'b00:   nbytes = 33'd1;
      2'b01:   nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
    end_addr = {1'b0, req_addr} + nbytes;
    err = (req_size == 2'b11)
       || ((req_size == 2'b01) && req_addr[0])
       || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
       || (end_addr > 33'(DEPTH_BYTES));
  end

  assign idx0 = req_addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign word = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

  always_comb begin
    load_data = word;
    unique case (req_size)
      2'b00: load_data = req_unsigned ? {24'b0, word[7:0]}
                                      : {{24{word[7]}}, word[7:0]};
      2'b01: load_data = req_unsigned ? {16'b0, word[15:0]}
                                      : {{16{word[15]}}, word[15:0]};
      default: load_data = word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          rsp_err_d   = err;
          rsp_rdata_d = (req_we || err) ? '0 : load_data;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = 3'd1;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_M1) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Array is deliberately not reset; stores commit on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && !err) begin
      mem[idx0] <= req_wdata[7:0];
      if (req_size != 2'b00) mem[idx1] <= req_wdata[15:8];
      if (req_size == 2'b10) begin
        mem[idx2] <= req_wdata[23:16];
        mem[idx3] <= req_wdata[31:24];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
